// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch stage.
// Default reset PC, instruction width and the canonical NOP encoding.
package inst_fetch_queue_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous circular FIFO for {pc, instr} entries.
// Pointers wrap modulo DEPTH; flush empties it in one cycle.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (push) wr_d = wr_q + PW'(1);
        if (pop)  rd_d = rd_q + PW'(1);
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: head is only observed when count is nonzero.
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: credit-limited sequential prefetch into a small queue,
// with branch redirect that flushes the queue and drops in-flight fetches.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              freeze,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchBase,
    input  logic [ADDR_W-1:0] branchOffset,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemRespValid,
    input  logic [DATA_W-1:0] imemRespData,
    output logic              outValid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] target;
    logic [EW-1:0]     head;
    logic              issue, push, pop;

    assign target = branchBase + (branchOffset << 2);
    assign issue  = !reset && !branchTaken
                 && (({1'b0, count} + {1'b0, out_q}) < SW'(DEPTH));
    assign push   = imemRespValid && (drop_q == '0) && !branchTaken;
    assign pop    = outValid && !freeze && !branchTaken;

    // Responses return in order and never skip, so the next accepted
    // response always belongs to resp_pc_q; no per-request tag store needed.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q + CW'(issue) - CW'(imemRespValid);
        drop_d     = drop_q;
        if (branchTaken) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            drop_d     = out_q - CW'(imemRespValid);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            if (push)  resp_pc_d  = resp_pc_q + ADDR_W'(4);
            if (imemRespValid && drop_q != '0) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (branchTaken),
        .din   ({resp_pc_q, imemRespData}),
        .count (count),
        .head  (head)
    );

    assign imemReq     = issue;
    assign imemAddr    = fetch_pc_q;
    assign outValid    = (count != '0);
    assign pc          = outValid ? head[EW-1:DATA_W] : '0;
    assign instruction = outValid ? head[DATA_W-1:0]  : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order variable-latency
// memory model and a PC scoreboard fed from observed fetch requests.
module tb_inst_fetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchBase = '0;
    logic [31:0] branchOffset = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = '0;
    logic        outValid;
    logic [31:0] pc;
    logic [31:0] instruction;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_addr = '0;
    logic [31:0] expv;
    req_t        r;

    inst_fetch_queue dut (
        .clock         (clock),
        .reset         (reset),
        .freeze        (freeze),
        .branchTaken   (branchTaken),
        .branchBase    (branchBase),
        .branchOffset  (branchOffset),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .outValid      (outValid),
        .pc            (pc),
        .instruction   (instruction)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory model and scoreboard, evaluated mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            mem_q.delete();
            model_addr = '0;
            imemRespValid = 1'b0;
            imemRespData = '0;
        end else begin
            if (outValid && !freeze && !branchTaken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow observed=%h expected=none", pc);
                end else begin
                    expv = exp_q.pop_front();
                    chk("sb_pc", pc, expv);
                    chk("sb_instr", instruction, ~expv);
                end
            end
            if (branchTaken) begin
                exp_q.delete();
                model_addr = branchBase + (branchOffset << 2);
            end
            if (imemReq) begin
                chk("req_addr", imemAddr, model_addr);
                exp_q.push_back(model_addr);
                mem_q.push_back('{imemAddr, cyc + lat});
                model_addr = model_addr + 32'd4;
            end
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                r = mem_q.pop_front();
                imemRespValid = 1'b1;
                imemRespData = ~r.a;
            end else begin
                imemRespValid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset then run, 1-cycle memory
        reset = 1'b1;
        lat = 1;
        tick();
        tick();
        @(negedge clock);
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_imemReq", 32'(imemReq), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("first_req", 32'(imemReq), 32'd1);
        chk("first_addr", imemAddr, 32'h0);
        tick();
        tick();
        @(negedge clock);
        chk("head0_valid", 32'(outValid), 32'd1);
        chk("head0_pc", pc, 32'h0);
        for (int i = 1; i < 6; i++) begin
            tick();
            @(negedge clock);
            chk("run_valid", 32'(outValid), 32'd1);
            chk("run_pc", pc, 32'(i * 4));
        end

        // Redirect with in-flight fetches, latency 3
        lat = 3;
        repeat (12) tick();
        branchBase = 32'h100;
        branchOffset = 32'h10;
        branchTaken = 1'b1;
        @(negedge clock);
        chk("br_noreq", 32'(imemReq), 32'd0);
        tick();
        branchTaken = 1'b0;
        @(negedge clock);
        chk("br_flush", 32'(outValid), 32'd0);
        n = 0;
        while (!outValid && n < 40) begin
            tick();
            @(negedge clock);
            n++;
        end
        chk("br_valid", 32'(outValid), 32'd1);
        chk("br_pc", pc, 32'h140);
        chk("br_instr", instruction, ~32'h140);

        // Redirect coincident with response and pop
        lat = 1;
        repeat (10) tick();
        branchBase = 32'h1F0;
        branchOffset = 32'h4;
        branchTaken = 1'b1;
        @(negedge clock);
        chk("co_pop_valid", 32'(outValid), 32'd1);
        chk("co_noreq", 32'(imemReq), 32'd0);
        tick();
        branchTaken = 1'b0;
        @(negedge clock);
        chk("co_flush", 32'(outValid), 32'd0);
        chk("co_req", 32'(imemReq), 32'd1);
        chk("co_addr", imemAddr, 32'h200);
        tick();
        @(negedge clock);
        chk("co_gap", 32'(outValid), 32'd0);
        tick();
        @(negedge clock);
        chk("co_valid", 32'(outValid), 32'd1);
        chk("co_pc", pc, 32'h200);

        // Address wrap
        repeat (3) tick();
        branchBase = 32'hFFFF_FFF8;
        branchOffset = 32'h0;
        branchTaken = 1'b1;
        tick();
        branchTaken = 1'b0;
        tick();
        tick();
        @(negedge clock);
        chk("wrap_pc0", pc, 32'hFFFF_FFF8);
        tick();
        @(negedge clock);
        chk("wrap_pc1", pc, 32'hFFFF_FFFC);
        tick();
        @(negedge clock);
        chk("wrap_pc2", pc, 32'h0000_0000);

        // Reset mid-stream with loaded queue and in-flight requests
        lat = 3;
        tick();
        freeze = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_noreq", 32'(imemReq), 32'd0);
        tick();
        lat = 1;
        @(negedge clock);
        chk("mrst_valid", 32'(outValid), 32'd0);
        chk("mrst_req", 32'(imemReq), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("mrst_first_req", 32'(imemReq), 32'd1);
        chk("mrst_first_addr", imemAddr, 32'h0);

        // Freeze fill
        repeat (9) tick();
        @(negedge clock);
        chk("frz_noreq", 32'(imemReq), 32'd0);
        chk("frz_valid", 32'(outValid), 32'd1);
        chk("frz_pc", pc, 32'h0);
        tick();
        freeze = 1'b0;
        @(negedge clock);
        chk("drain_pc", pc, 32'h0);
        for (int i = 1; i < 5; i++) begin
            tick();
            @(negedge clock);
            chk("drain_valid", 32'(outValid), 32'd1);
            chk("drain_pc", pc, 32'(i * 4));
        end

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
